// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory port arbiter.
//   - default address/data widths and starvation limit
//   - arbiter state encoding
//   - owner encoding (which requester holds / last held the port)
package mem_arb_pkg;

    localparam int unsigned DEF_AW         = 16;
    localparam int unsigned DEF_DW         = 16;
    localparam int unsigned DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } arb_state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_TR  = 1'b1;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive arbitrations the transfer side lost to the CPU.
//   clk     in   system clock
//   rst_n   in   synchronous reset, active low
//   inc     in   transfer requested but the CPU won this arbitration
//   clr     in   transfer won, or no transfer request (clr has priority)
//   at_max  out  count has reached STARVE_MAX; transfer must win next
module arb_starve_counter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CW-1:0] count_q, count_d;

    assign at_max = (count_q == CW'(STARVE_MAX));

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !at_max) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single synchronous main-memory port between the CPU (REM/RDM path)
// and the memory/disk transfer engine. CPU has fixed priority except when a
// locked transfer burst holds the port or the transfer side has starved.
//   clk, rst_n                          clock, synchronous active-low reset
//   req_c/we_c/addr_c/wdata_c           CPU request (held until ack_c)
//   ack_c/rdata_c/wait_c                CPU completion pulse, read data, stall
//   req_t/we_t/addr_t/wdata_t/lock_t    transfer request and burst lock
//   ack_t/rdata_t                       transfer completion pulse, read data
//   mem_addr/mem_data/mem_we            registered memory command
//   mem_q                               memory read data (one cycle after address)
//   owner                               0 = CPU, 1 = transfer (last/current grant)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW         = DEF_AW,
    parameter int unsigned DW         = DEF_DW,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_c,
    input  logic          we_c,
    input  logic [AW-1:0] addr_c,
    input  logic [DW-1:0] wdata_c,
    output logic          ack_c,
    output logic [DW-1:0] rdata_c,
    output logic          wait_c,
    input  logic          req_t,
    input  logic          we_t,
    input  logic [AW-1:0] addr_t,
    input  logic [DW-1:0] wdata_t,
    input  logic          lock_t,
    output logic          ack_t,
    output logic [DW-1:0] rdata_t,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_we,
    input  logic [DW-1:0] mem_q,
    output logic          owner
);

    arb_state_e    state_q, state_d;
    logic          owner_q, owner_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    logic          mem_we_q, mem_we_d;

    logic in_resp;
    logic eff_req_c, eff_req_t;
    logic lock_hold;
    logic grant_c, grant_t;
    logic starve_inc, starve_clr, starve_at_max;

    arb_starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .at_max (starve_at_max)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = 1'b0;
        starve_inc = 1'b0;
        starve_clr = 1'b0;
        grant_c    = 1'b0;
        grant_t    = 1'b0;

        // The requester being acked this cycle is not re-granted in the same cycle.
        in_resp   = (state_q == StResp);
        eff_req_c = req_c & ~(in_resp & (owner_q == OWN_CPU));
        eff_req_t = req_t & ~(in_resp & (owner_q == OWN_TR));

        // A locked burst keeps the port even in the ack cycle where req_t is masked:
        // nobody is granted then, and the transfer side wins from IDLE next cycle.
        lock_hold = (owner_q == OWN_TR) & lock_t & req_t;

        if (lock_hold) begin
            grant_t = eff_req_t;
        end else if (starve_at_max && eff_req_t) begin
            grant_t = 1'b1;
        end else if (eff_req_c) begin
            grant_c = 1'b1;
        end else if (eff_req_t) begin
            grant_t = 1'b1;
        end

        unique case (state_q)
            StIdle, StResp: begin
                if (!lock_hold) begin
                    if (grant_c && eff_req_t) begin
                        starve_inc = 1'b1;
                    end else begin
                        starve_clr = 1'b1;
                    end
                end
                if (grant_c) begin
                    state_d    = StIssue;
                    owner_d    = OWN_CPU;
                    mem_addr_d = addr_c;
                    mem_data_d = wdata_c;
                    mem_we_d   = we_c;
                end else if (grant_t) begin
                    state_d    = StIssue;
                    owner_d    = OWN_TR;
                    mem_addr_d = addr_t;
                    mem_data_d = wdata_t;
                    mem_we_d   = we_t;
                end else begin
                    state_d = StIdle;
                end
            end
            StIssue: begin
                state_d = StResp;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            owner_q    <= OWN_CPU;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_we_q   <= mem_we_d;
        end
    end

    // Acks decode registered state only, so wait_c has no path from req_c back to req_c.
    assign ack_c    = (state_q == StResp) & (owner_q == OWN_CPU);
    assign ack_t    = (state_q == StResp) & (owner_q == OWN_TR);
    assign wait_c   = req_c & ~ack_c;
    assign rdata_c  = mem_q;
    assign rdata_t  = mem_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_we   = mem_we_q;
    assign owner    = owner_q;

endmodule
